// File: rtl/op_decode_stage_pkg.sv
// Shared 6502 decode vocabulary: instruction ids (alphabetical mnemonic order),
// addressing modes and the decoded-result record.
package nes6502_pkg;
  localparam int NUM_INST = 56;

  localparam logic [5:0]
    ID_ADC = 6'd0,  ID_AND = 6'd1,  ID_ASL = 6'd2,  ID_BCC = 6'd3,  ID_BCS = 6'd4,  ID_BEQ = 6'd5,
    ID_BIT = 6'd6,  ID_BMI = 6'd7,  ID_BNE = 6'd8,  ID_BPL = 6'd9,  ID_BRK = 6'd10, ID_BVC = 6'd11,
    ID_BVS = 6'd12, ID_CLC = 6'd13, ID_CLD = 6'd14, ID_CLI = 6'd15, ID_CLV = 6'd16, ID_CMP = 6'd17,
    ID_CPX = 6'd18, ID_CPY = 6'd19, ID_DEC = 6'd20, ID_DEX = 6'd21, ID_DEY = 6'd22, ID_EOR = 6'd23,
    ID_INC = 6'd24, ID_INX = 6'd25, ID_INY = 6'd26, ID_JMP = 6'd27, ID_JSR = 6'd28, ID_LDA = 6'd29,
    ID_LDX = 6'd30, ID_LDY = 6'd31, ID_LSR = 6'd32, ID_NOP = 6'd33, ID_ORA = 6'd34, ID_PHA = 6'd35,
    ID_PHP = 6'd36, ID_PLA = 6'd37, ID_PLP = 6'd38, ID_ROL = 6'd39, ID_ROR = 6'd40, ID_RTI = 6'd41,
    ID_RTS = 6'd42, ID_SBC = 6'd43, ID_SEC = 6'd44, ID_SED = 6'd45, ID_SEI = 6'd46, ID_STA = 6'd47,
    ID_STX = 6'd48, ID_STY = 6'd49, ID_TAX = 6'd50, ID_TAY = 6'd51, ID_TSX = 6'd52, ID_TXA = 6'd53,
    ID_TXS = 6'd54, ID_TYA = 6'd55, ID_UNK = 6'd63;

  localparam logic [3:0]
    M_IMP = 4'd0, M_ACC = 4'd1, M_IMM = 4'd2,  M_ZP  = 4'd3,  M_ZPX = 4'd4,  M_ZPY = 4'd5, M_ABS = 4'd6,
    M_ABX = 4'd7, M_ABY = 4'd8, M_IND = 4'd9,  M_IZX = 4'd10, M_IZY = 4'd11, M_REL = 4'd12;

  typedef struct packed {
    logic [5:0] inst_id;
    logic [3:0] mode;
    logic [1:0] len;
    logic       unknown;
  } dec_t;

  // Instruction length follows from the addressing mode alone (BRK decodes as IMP).
  function automatic logic [1:0] mode_len(input logic [3:0] mode);
    case (mode)
      M_IMP, M_ACC:               mode_len = 2'd1;
      M_ABS, M_ABX, M_ABY, M_IND: mode_len = 2'd3;
      default:                    mode_len = 2'd2;
    endcase
  endfunction
endpackage

// File: rtl/op_decode_stage_if.sv
// Fetch-side opcode channel and execute-side decoded-result channel of the decode stage.
interface op_decode_stage_if;
  import nes6502_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [7:0]          in_opcode;
  logic                out_valid;
  logic                out_ready;
  logic [7:0]          out_opcode;
  logic [5:0]          out_inst_id;
  logic [NUM_INST-1:0] out_onehot;
  logic [3:0]          out_mode;
  logic [1:0]          out_len;
  logic                out_unknown;

  modport master (
    output in_valid, in_opcode, out_ready,
    input  in_ready, out_valid, out_opcode, out_inst_id, out_onehot, out_mode, out_len, out_unknown
  );

  modport slave (
    input  in_valid, in_opcode, out_ready,
    output in_ready, out_valid, out_opcode, out_inst_id, out_onehot, out_mode, out_len, out_unknown
  );
endinterface

// File: rtl/op_decode_stage_table.sv
// Combinational 6502 opcode lookup covering the 151 documented opcodes; anything else is unknown.
module op_decode_table
  import nes6502_pkg::*;
(
  input  logic [7:0] opcode_i,
  output dec_t       dec_o
);
  logic [9:0] r;

  always_comb begin
    r = {ID_UNK, M_IMP};
    case (opcode_i)
      8'h69: r = {ID_ADC, M_IMM}; 8'h65: r = {ID_ADC, M_ZP};  8'h75: r = {ID_ADC, M_ZPX}; 8'h6D: r = {ID_ADC, M_ABS};
      8'h7D: r = {ID_ADC, M_ABX}; 8'h79: r = {ID_ADC, M_ABY}; 8'h61: r = {ID_ADC, M_IZX}; 8'h71: r = {ID_ADC, M_IZY};
      8'h29: r = {ID_AND, M_IMM}; 8'h25: r = {ID_AND, M_ZP};  8'h35: r = {ID_AND, M_ZPX}; 8'h2D: r = {ID_AND, M_ABS};
      8'h3D: r = {ID_AND, M_ABX}; 8'h39: r = {ID_AND, M_ABY}; 8'h21: r = {ID_AND, M_IZX}; 8'h31: r = {ID_AND, M_IZY};
      8'h0A: r = {ID_ASL, M_ACC}; 8'h06: r = {ID_ASL, M_ZP};  8'h16: r = {ID_ASL, M_ZPX}; 8'h0E: r = {ID_ASL, M_ABS};
      8'h1E: r = {ID_ASL, M_ABX};
      8'h90: r = {ID_BCC, M_REL}; 8'hB0: r = {ID_BCS, M_REL}; 8'hF0: r = {ID_BEQ, M_REL}; 8'h30: r = {ID_BMI, M_REL};
      8'hD0: r = {ID_BNE, M_REL}; 8'h10: r = {ID_BPL, M_REL}; 8'h50: r = {ID_BVC, M_REL}; 8'h70: r = {ID_BVS, M_REL};
      8'h24: r = {ID_BIT, M_ZP};  8'h2C: r = {ID_BIT, M_ABS}; 8'h00: r = {ID_BRK, M_IMP};
      8'h18: r = {ID_CLC, M_IMP}; 8'hD8: r = {ID_CLD, M_IMP}; 8'h58: r = {ID_CLI, M_IMP}; 8'hB8: r = {ID_CLV, M_IMP};
      8'hC9: r = {ID_CMP, M_IMM}; 8'hC5: r = {ID_CMP, M_ZP};  8'hD5: r = {ID_CMP, M_ZPX}; 8'hCD: r = {ID_CMP, M_ABS};
      8'hDD: r = {ID_CMP, M_ABX}; 8'hD9: r = {ID_CMP, M_ABY}; 8'hC1: r = {ID_CMP, M_IZX}; 8'hD1: r = {ID_CMP, M_IZY};
      8'hE0: r = {ID_CPX, M_IMM}; 8'hE4: r = {ID_CPX, M_ZP};  8'hEC: r = {ID_CPX, M_ABS};
      8'hC0: r = {ID_CPY, M_IMM}; 8'hC4: r = {ID_CPY, M_ZP};  8'hCC: r = {ID_CPY, M_ABS};
      8'hC6: r = {ID_DEC, M_ZP};  8'hD6: r = {ID_DEC, M_ZPX}; 8'hCE: r = {ID_DEC, M_ABS}; 8'hDE: r = {ID_DEC, M_ABX};
      8'hCA: r = {ID_DEX, M_IMP}; 8'h88: r = {ID_DEY, M_IMP};
      8'h49: r = {ID_EOR, M_IMM}; 8'h45: r = {ID_EOR, M_ZP};  8'h55: r = {ID_EOR, M_ZPX}; 8'h4D: r = {ID_EOR, M_ABS};
      8'h5D: r = {ID_EOR, M_ABX}; 8'h59: r = {ID_EOR, M_ABY}; 8'h41: r = {ID_EOR, M_IZX}; 8'h51: r = {ID_EOR, M_IZY};
      8'hE6: r = {ID_INC, M_ZP};  8'hF6: r = {ID_INC, M_ZPX}; 8'hEE: r = {ID_INC, M_ABS}; 8'hFE: r = {ID_INC, M_ABX};
      8'hE8: r = {ID_INX, M_IMP}; 8'hC8: r = {ID_INY, M_IMP};
      8'h4C: r = {ID_JMP, M_ABS}; 8'h6C: r = {ID_JMP, M_IND}; 8'h20: r = {ID_JSR, M_ABS};
      8'hA9: r = {ID_LDA, M_IMM}; 8'hA5: r = {ID_LDA, M_ZP};  8'hB5: r = {ID_LDA, M_ZPX}; 8'hAD: r = {ID_LDA, M_ABS};
      8'hBD: r = {ID_LDA, M_ABX}; 8'hB9: r = {ID_LDA, M_ABY}; 8'hA1: r = {ID_LDA, M_IZX}; 8'hB1: r = {ID_LDA, M_IZY};
      8'hA2: r = {ID_LDX, M_IMM}; 8'hA6: r = {ID_LDX, M_ZP};  8'hB6: r = {ID_LDX, M_ZPY}; 8'hAE: r = {ID_LDX, M_ABS};
      8'hBE: r = {ID_LDX, M_ABY};
      8'hA0: r = {ID_LDY, M_IMM}; 8'hA4: r = {ID_LDY, M_ZP};  8'hB4: r = {ID_LDY, M_ZPX}; 8'hAC: r = {ID_LDY, M_ABS};
      8'hBC: r = {ID_LDY, M_ABX};
      8'h4A: r = {ID_LSR, M_ACC}; 8'h46: r = {ID_LSR, M_ZP};  8'h56: r = {ID_LSR, M_ZPX}; 8'h4E: r = {ID_LSR, M_ABS};
      8'h5E: r = {ID_LSR, M_ABX}; 8'hEA: r = {ID_NOP, M_IMP};
      8'h09: r = {ID_ORA, M_IMM}; 8'h05: r = {ID_ORA, M_ZP};  8'h15: r = {ID_ORA, M_ZPX}; 8'h0D: r = {ID_ORA, M_ABS};
      8'h1D: r = {ID_ORA, M_ABX}; 8'h19: r = {ID_ORA, M_ABY}; 8'h01: r = {ID_ORA, M_IZX}; 8'h11: r = {ID_ORA, M_IZY};
      8'h48: r = {ID_PHA, M_IMP}; 8'h08: r = {ID_PHP, M_IMP}; 8'h68: r = {ID_PLA, M_IMP}; 8'h28: r = {ID_PLP, M_IMP};
      8'h2A: r = {ID_ROL, M_ACC}; 8'h26: r = {ID_ROL, M_ZP};  8'h36: r = {ID_ROL, M_ZPX}; 8'h2E: r = {ID_ROL, M_ABS};
      8'h3E: r = {ID_ROL, M_ABX};
      8'h6A: r = {ID_ROR, M_ACC}; 8'h66: r = {ID_ROR, M_ZP};  8'h76: r = {ID_ROR, M_ZPX}; 8'h6E: r = {ID_ROR, M_ABS};
      8'h7E: r = {ID_ROR, M_ABX}; 8'h40: r = {ID_RTI, M_IMP}; 8'h60: r = {ID_RTS, M_IMP};
      8'hE9: r = {ID_SBC, M_IMM}; 8'hE5: r = {ID_SBC, M_ZP};  8'hF5: r = {ID_SBC, M_ZPX}; 8'hED: r = {ID_SBC, M_ABS};
      8'hFD: r = {ID_SBC, M_ABX}; 8'hF9: r = {ID_SBC, M_ABY}; 8'hE1: r = {ID_SBC, M_IZX}; 8'hF1: r = {ID_SBC, M_IZY};
      8'h38: r = {ID_SEC, M_IMP}; 8'hF8: r = {ID_SED, M_IMP}; 8'h78: r = {ID_SEI, M_IMP};
      8'h85: r = {ID_STA, M_ZP};  8'h95: r = {ID_STA, M_ZPX}; 8'h8D: r = {ID_STA, M_ABS}; 8'h9D: r = {ID_STA, M_ABX};
      8'h99: r = {ID_STA, M_ABY}; 8'h81: r = {ID_STA, M_IZX}; 8'h91: r = {ID_STA, M_IZY};
      8'h86: r = {ID_STX, M_ZP};  8'h96: r = {ID_STX, M_ZPY}; 8'h8E: r = {ID_STX, M_ABS};
      8'h84: r = {ID_STY, M_ZP};  8'h94: r = {ID_STY, M_ZPX}; 8'h8C: r = {ID_STY, M_ABS};
      8'hAA: r = {ID_TAX, M_IMP}; 8'hA8: r = {ID_TAY, M_IMP}; 8'hBA: r = {ID_TSX, M_IMP}; 8'h8A: r = {ID_TXA, M_IMP};
      8'h9A: r = {ID_TXS, M_IMP}; 8'h98: r = {ID_TYA, M_IMP};
      default: r = {ID_UNK, M_IMP};
    endcase
  end

  assign dec_o.inst_id = r[9:4];
  assign dec_o.mode    = r[3:0];
  assign dec_o.len     = mode_len(r[3:0]);
  assign dec_o.unknown = (r[9:4] == ID_UNK);
endmodule

// File: rtl/op_decode_stage.sv
// Registered 6502 opcode decode stage between fetch and execute: one-deep output register,
// RUN/HALT control for illegal opcodes and a saturating illegal-opcode counter.
module op_decode_stage
  import nes6502_pkg::*;
#(
  parameter bit HALT_ON_UNKNOWN = 1'b1,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  op_decode_stage_if.slave bus,
  input  logic             flush,
  input  logic             halt_clr,
  output logic             halted,
  output logic [CNT_W-1:0] unk_count
);
  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  logic [0:0]          state_q, state_d;
  logic                valid_q, valid_d;
  logic [7:0]          opcode_q, opcode_d;
  dec_t                dec_q, dec_d, tab;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                in_ready, accept;
  logic [NUM_INST-1:0] onehot;

  op_decode_table u_table (
    .opcode_i (bus.in_opcode),
    .dec_o    (tab)
  );

  assign in_ready = (state_q == ST_RUN) && (!valid_q || bus.out_ready) && !flush;
  assign accept   = bus.in_valid && in_ready;

  // flush has priority: a held result is dropped even if execute is ready for it.
  always_comb begin
    valid_d  = valid_q;
    opcode_d = opcode_q;
    dec_d    = dec_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d  = 1'b1;
      opcode_d = bus.in_opcode;
      dec_d    = tab;
    end else if (bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_RUN) begin
      if (accept && tab.unknown && HALT_ON_UNKNOWN) state_d = ST_HALT;
    end else if (halt_clr) begin
      state_d = ST_RUN;
    end
  end

  assign cnt_d = (accept && tab.unknown && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      valid_q  <= 1'b0;
      opcode_q <= '0;
      dec_q    <= '{inst_id: ID_UNK, mode: M_IMP, len: 2'd0, unknown: 1'b0};
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      opcode_q <= opcode_d;
      dec_q    <= dec_d;
      cnt_q    <= cnt_d;
    end
  end

  // ID_UNK lies outside 0..NUM_INST-1, so an unknown opcode yields an all-zero vector.
  always_comb begin
    onehot = '0;
    for (int n = 0; n < NUM_INST; n++) onehot[n] = (dec_q.inst_id == 6'(n));
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = valid_q;
  assign bus.out_opcode  = opcode_q;
  assign bus.out_inst_id = dec_q.inst_id;
  assign bus.out_onehot  = onehot;
  assign bus.out_mode    = dec_q.mode;
  assign bus.out_len     = dec_q.len;
  assign bus.out_unknown = dec_q.unknown;
  assign halted          = (state_q == ST_HALT);
  assign unk_count       = cnt_q;
endmodule

// File: tb/tb_op_decode_stage.sv
// Bench for op_decode_stage: dut0 passes illegal opcodes through (16-bit counter),
// dut1 halts on them (2-bit counter, to reach saturation quickly).
module tb_op_decode_stage;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  op_decode_stage_if if0();
  op_decode_stage_if if1();
  logic        flush0, flush1, hclr0, hclr1, halted0, halted1;
  logic [15:0] cnt0;
  logic [1:0]  cnt1;

  op_decode_stage #(.HALT_ON_UNKNOWN(1'b0), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0), .flush(flush0), .halt_clr(hclr0),
    .halted(halted0), .unk_count(cnt0)
  );
  op_decode_stage #(.HALT_ON_UNKNOWN(1'b1), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1), .flush(flush1), .halt_clr(hclr1),
    .halted(halted1), .unk_count(cnt1)
  );

  bit          sel;
  logic        o_valid, i_ready, o_unk, o_halted;
  logic [7:0]  o_op;
  logic [5:0]  o_id;
  logic [55:0] o_hot;
  logic [3:0]  o_mode;
  logic [1:0]  o_len;
  logic [15:0] o_cnt;

  always_comb begin
    if (sel) begin
      o_valid = if1.out_valid; i_ready = if1.in_ready; o_unk = if1.out_unknown; o_halted = halted1;
      o_op = if1.out_opcode; o_id = if1.out_inst_id; o_hot = if1.out_onehot;
      o_mode = if1.out_mode; o_len = if1.out_len; o_cnt = {14'd0, cnt1};
    end else begin
      o_valid = if0.out_valid; i_ready = if0.in_ready; o_unk = if0.out_unknown; o_halted = halted0;
      o_op = if0.out_opcode; o_id = if0.out_inst_id; o_hot = if0.out_onehot;
      o_mode = if0.out_mode; o_len = if0.out_len; o_cnt = cnt0;
    end
  end

  typedef struct {
    logic [7:0] op;
    logic [5:0] id;
    logic [3:0] mode;
    logic [1:0] len;
    logic       unk;
    bit         full;
  } exp_t;

  exp_t sb[$];
  exp_t vec[19];
  exp_t nil, vA9, vE8, v02, vFF, v4C;
  int errors = 0, checks = 0, known_cnt = 0, acc_cnt = 0;

  function automatic exp_t mk(input logic [7:0] op, input logic [5:0] id, input logic [3:0] m,
                              input logic [1:0] len, input logic unk);
    exp_t e;
    e.op = op; e.id = id; e.mode = m; e.len = len; e.unk = unk; e.full = 1'b1;
    return e;
  endfunction

  function automatic exp_t sw(input logic [7:0] op);
    exp_t e;
    e.op = op; e.id = 6'd0; e.mode = 4'd0; e.len = 2'd0; e.unk = 1'b0; e.full = 1'b0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic idle_all();
    if0.in_valid = 1'b0; if0.in_opcode = 8'h00; if0.out_ready = 1'b0; flush0 = 1'b0; hclr0 = 1'b0;
    if1.in_valid = 1'b0; if1.in_opcode = 8'h00; if1.out_ready = 1'b0; flush1 = 1'b0; hclr1 = 1'b0;
  endtask

  task automatic consume();
    exp_t e;
    logic [55:0] hot;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_result: got opcode %0h, required none outstanding", o_op);
      return;
    end
    e = sb.pop_front();
    chk("out_opcode", o_op, e.op);
    hot = (o_id < 6'd56) ? (56'd1 << o_id) : 56'd0;
    chk("onehot_vs_id", o_hot, hot);
    if (!o_unk) known_cnt++;
    if (e.full) begin
      chk("inst_id", o_id, e.id);
      chk("unknown", o_unk, e.unk);
      if (!e.unk) begin
        chk("mode", o_mode, e.mode);
        chk("len", o_len, e.len);
      end
    end
  endtask

  // One clock: drive after negedge, settle, then score what the coming posedge will do.
  task automatic cyc(input bit v, input exp_t e, input bit ordy, input bit fl, input bit hc);
    @(negedge clk);
    idle_all();
    if (sel) begin
      if1.in_valid = v; if1.in_opcode = e.op; if1.out_ready = ordy; flush1 = fl; hclr1 = hc;
    end else begin
      if0.in_valid = v; if0.in_opcode = e.op; if0.out_ready = ordy; flush0 = fl; hclr0 = hc;
    end
    #1;
    if (fl) begin
      if (o_valid && sb.size() > 0) sb.delete(0);
    end else if (o_valid && ordy) begin
      consume();
    end
    if (v && i_ready) begin
      sb.push_back(e);
      acc_cnt++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_all();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
  endtask

  task automatic check_reset(input string t);
    chk({t, "_out_valid"}, o_valid, 0);
    chk({t, "_inst_id"}, o_id, 63);
    chk({t, "_onehot"}, o_hot, 0);
    chk({t, "_mode"}, o_mode, 0);
    chk({t, "_len"}, o_len, 0);
    chk({t, "_unknown"}, o_unk, 0);
    chk({t, "_opcode"}, o_op, 0);
    chk({t, "_halted"}, o_halted, 0);
    chk({t, "_unk_count"}, o_cnt, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle_all();
    rst_n = 1'b0;
    sel = 1'b0;
    nil = sw(8'h00);
    vec[0]  = mk(8'hA9, 29, 2, 2, 0);  vec[1]  = mk(8'h6C, 27, 9, 3, 0);
    vec[2]  = mk(8'h4C, 27, 6, 3, 0);  vec[3]  = mk(8'h20, 28, 6, 3, 0);
    vec[4]  = mk(8'h00, 10, 0, 1, 0);  vec[5]  = mk(8'h0A, 2, 1, 1, 0);
    vec[6]  = mk(8'h6A, 40, 1, 1, 0);  vec[7]  = mk(8'hD0, 8, 12, 2, 0);
    vec[8]  = mk(8'hB6, 30, 5, 2, 0);  vec[9]  = mk(8'h96, 48, 5, 2, 0);
    vec[10] = mk(8'hBE, 30, 8, 3, 0);  vec[11] = mk(8'hB1, 29, 11, 2, 0);
    vec[12] = mk(8'h61, 0, 10, 2, 0);  vec[13] = mk(8'hFD, 43, 7, 3, 0);
    vec[14] = mk(8'h75, 0, 4, 2, 0);   vec[15] = mk(8'hE8, 25, 0, 1, 0);
    vec[16] = mk(8'h9A, 54, 0, 1, 0);  vec[17] = mk(8'h02, 63, 0, 0, 1);
    vec[18] = mk(8'hFF, 63, 0, 0, 1);
    vA9 = vec[0]; vE8 = vec[15]; v02 = vec[17]; vFF = vec[18]; v4C = vec[2];

    repeat (2) @(negedge clk);
    #1;
    check_reset("rst0");
    sel = 1'b1; #1;
    check_reset("rst1");
    sel = 1'b0; #1;
    rst_n = 1'b1;

    // Table-driven decode, streamed back-to-back
    foreach (vec[i]) begin
      cyc(1, vec[i], 1, 0, 0);
      chk("stream_ready", i_ready, 1);
    end
    cyc(0, nil, 1, 0, 0);
    chk("table_drained", sb.size(), 0);
    chk("table_unk_count", o_cnt, 2);
    cyc(0, nil, 1, 0, 0);
    chk("table_valid_drop", o_valid, 0);

    // Full opcode sweep
    do_reset();
    known_cnt = 0; acc_cnt = 0;
    for (int i = 0; i < 256; i++) cyc(1, sw(8'(i)), 1, 0, 0);
    cyc(0, nil, 1, 0, 0);
    chk("sweep_accepts", acc_cnt, 256);
    chk("sweep_known", known_cnt, 151);
    chk("sweep_unk_count", o_cnt, 105);
    chk("sweep_drained", sb.size(), 0);

    // Backpressure
    cyc(1, vE8, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(1, vA9, 0, 0, 0);
      chk("bp_valid", o_valid, 1);
      chk("bp_inst_id", o_id, 25);
      chk("bp_opcode", o_op, 8'hE8);
      chk("bp_in_ready", i_ready, 0);
    end
    cyc(1, vA9, 1, 0, 0);
    chk("bp_accept_on_release", i_ready, 1);
    cyc(0, nil, 1, 0, 0);
    cyc(0, nil, 1, 0, 0);
    chk("bp_valid_drop", o_valid, 0);
    chk("bp_drained", sb.size(), 0);

    // Flush of a held result, then flush racing out_ready
    cyc(1, v4C, 1, 0, 0);
    cyc(0, nil, 0, 0, 0);
    chk("flush_held_valid", o_valid, 1);
    cyc(1, vA9, 0, 1, 0);
    chk("flush_in_ready", i_ready, 0);
    cyc(0, nil, 0, 0, 0);
    chk("flush_valid", o_valid, 0);
    cyc(1, vFF, 1, 0, 0);
    cyc(0, nil, 1, 1, 0);
    cyc(0, nil, 1, 0, 0);
    chk("flush_ordy_valid", o_valid, 0);
    chk("flush_unk_count", o_cnt, 106);
    chk("flush_drained", sb.size(), 0);

    // Halt on unknown (dut1)
    sel = 1'b1;
    cyc(0, nil, 1, 0, 1);
    cyc(0, nil, 1, 0, 0);
    chk("halt_clr_in_run", o_halted, 0);
    cyc(1, vA9, 1, 0, 0);
    cyc(1, v02, 1, 0, 0);
    cyc(1, vA9, 0, 0, 0);
    chk("halt_valid", o_valid, 1);
    chk("halt_unknown", o_unk, 1);
    chk("halt_inst_id", o_id, 63);
    chk("halt_halted", o_halted, 1);
    chk("halt_in_ready", i_ready, 0);
    cyc(1, vA9, 1, 0, 0);
    chk("halt_no_accept", i_ready, 0);
    cyc(1, vA9, 1, 1, 0);
    cyc(0, nil, 1, 0, 0);
    chk("halt_after_flush", o_halted, 1);
    cyc(0, nil, 1, 0, 1);
    cyc(1, vA9, 1, 0, 0);
    chk("halt_cleared", o_halted, 0);
    chk("halt_clr_ready", i_ready, 1);
    cyc(0, nil, 1, 0, 0);
    chk("halt_drained", sb.size(), 0);
    chk("halt_unk_count", o_cnt, 1);

    // Counter saturation (2-bit counter on dut1)
    for (int k = 0; k < 3; k++) begin
      cyc(1, v02, 1, 0, 0);
      chk("sat_accept", i_ready, 1);
      cyc(0, nil, 1, 0, 1);
    end
    cyc(0, nil, 1, 0, 0);
    chk("sat_unk_count", o_cnt, 3);
    chk("sat_drained", sb.size(), 0);

    // Asynchronous reset while halted with a held result
    cyc(1, v02, 1, 0, 0);
    cyc(0, nil, 0, 0, 0);
    chk("pre_rst_halted", o_halted, 1);
    chk("pre_rst_valid", o_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check_reset("rst_mid1");
    sel = 1'b0; #1;
    check_reset("rst_mid0");
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
